// File: rtl/gin_pkg.sv
// ============================================================================
// gin_pkg : shared types, geometry constants and helpers for the GIN receiver
// Revision: 1.0
// ============================================================================
`default_nettype none

package gin_pkg;

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    HOLD  = 1'b1
  } gin_state_e;

  localparam int GIN_ROWS   = 6;
  localparam int GIN_COLS   = 8;
  localparam int GIN_NUM_PE = GIN_ROWS * GIN_COLS;

  // PEs are numbered row-major, so the row is the quotient by the column count.
  function automatic int pe_row(input int i, input int cols = GIN_COLS);
    return i / cols;
  endfunction

endpackage

`default_nettype wire

// File: rtl/gin_id_scan_chain.sv
// ============================================================================
// gin_id_scan_chain : ID shift register with parallel read-out
// Revision: 1.0
// ============================================================================
`default_nettype none

module gin_id_scan_chain #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   shift_en,
  input  logic [WIDTH-1:0]       scan_in,
  output logic [DEPTH*WIDTH-1:0] ids
);

  // Entry k sits at ids[k*WIDTH +: WIDTH]; new values enter at the top entry
  // and walk toward entry 0, so the first value shifted ends up in entry 0.
  generate
    if (DEPTH == 1) begin : g_single
      always_ff @(posedge clk) begin
        if (!rst_n)        ids <= '0;
        else if (shift_en) ids <= scan_in;
      end
    end else begin : g_chain
      always_ff @(posedge clk) begin
        if (!rst_n)        ids <= '0;
        else if (shift_en) ids <= {scan_in, ids[DEPTH*WIDTH-1:WIDTH]};
      end
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/gin_channel_receiver.sv
// ============================================================================
// gin_channel_receiver : GIN channel endpoint, tag match + single-slot multicast
// Revision: 1.0
// ============================================================================
`default_nettype none

module gin_channel_receiver
  import gin_pkg::*;
#(
  parameter int NUMS_PE_ROW = GIN_ROWS,
  parameter int NUMS_PE_COL = GIN_COLS,
  parameter int XID_BITS    = 5,
  parameter int YID_BITS    = 3,
  parameter int DATA_SIZE   = 32
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               set_XID,
  input  logic [XID_BITS-1:0]                XID_scan_in,
  input  logic                               set_YID,
  input  logic [YID_BITS-1:0]                YID_scan_in,
  input  logic [NUMS_PE_ROW*NUMS_PE_COL-1:0] PE_en,
  input  logic                               GLB_valid,
  output logic                               GLB_ready,
  input  logic [XID_BITS-1:0]                tag_X,
  input  logic [YID_BITS-1:0]                tag_Y,
  input  logic [DATA_SIZE-1:0]               data_in,
  output logic [NUMS_PE_ROW*NUMS_PE_COL-1:0] PE_valid,
  input  logic [NUMS_PE_ROW*NUMS_PE_COL-1:0] PE_ready,
  output logic [DATA_SIZE-1:0]               PE_data,
  output logic                               busy
);

  localparam int N = NUMS_PE_ROW * NUMS_PE_COL;

  logic [N*XID_BITS-1:0]           xid;
  logic [NUMS_PE_ROW*YID_BITS-1:0] yid;
  logic [N-1:0]                    match;

  gin_state_e                      state, state_next;
  logic [N-1:0]                    pending, pending_next, pending_left;
  logic [DATA_SIZE-1:0]            data_q, data_next;

  gin_id_scan_chain #(.DEPTH(N), .WIDTH(XID_BITS)) u_xid_chain (
    .clk      (clk),
    .rst_n    (rst_n),
    .shift_en (set_XID),
    .scan_in  (XID_scan_in),
    .ids      (xid)
  );

  gin_id_scan_chain #(.DEPTH(NUMS_PE_ROW), .WIDTH(YID_BITS)) u_yid_chain (
    .clk      (clk),
    .rst_n    (rst_n),
    .shift_en (set_YID),
    .scan_in  (YID_scan_in),
    .ids      (yid)
  );

  generate
    for (genvar i = 0; i < N; i++) begin : g_match
      localparam int ROW = pe_row(i, NUMS_PE_COL);
      assign match[i] = PE_en[i]
                     && (xid[i*XID_BITS +: XID_BITS] == tag_X)
                     && (yid[ROW*YID_BITS +: YID_BITS] == tag_Y);
    end
  endgenerate

  assign pending_left = pending & ~PE_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= EMPTY;
      pending <= '0;
      data_q  <= '0;
    end else begin
      state   <= state_next;
      pending <= pending_next;
      data_q  <= data_next;
    end
  end

  // A handshake with no matching PE is consumed without occupying the slot.
  always_comb begin
    state_next   = state;
    pending_next = pending;
    data_next    = data_q;
    case (state)
      EMPTY: begin
        if (GLB_valid && (|match)) begin
          state_next   = HOLD;
          pending_next = match;
          data_next    = data_in;
        end
      end
      HOLD: begin
        pending_next = pending_left;
        if (pending_left == '0) state_next = EMPTY;
      end
      default: state_next = EMPTY;
    endcase
  end

  always_comb begin
    GLB_ready = (state == EMPTY);
    busy      = (state == HOLD);
    PE_valid  = (state == HOLD) ? pending : '0;
  end

  assign PE_data = data_q;

endmodule

`default_nettype wire

// File: tb/tb_gin_channel_receiver.sv
// ============================================================================
// tb_gin_channel_receiver : directed vectors for the GIN channel receiver
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_gin_channel_receiver;

  localparam int ROWS = 6;
  localparam int COLS = 8;
  localparam int N    = ROWS * COLS;
  localparam int XB   = 5;
  localparam int YB   = 3;
  localparam int DB   = 32;
  localparam logic [N-1:0] ALL = '1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          set_XID;
  logic [XB-1:0] XID_scan_in;
  logic          set_YID;
  logic [YB-1:0] YID_scan_in;
  logic [N-1:0]  PE_en;
  logic          GLB_valid;
  logic          GLB_ready;
  logic [XB-1:0] tag_X;
  logic [YB-1:0] tag_Y;
  logic [DB-1:0] data_in;
  logic [N-1:0]  PE_valid;
  logic [N-1:0]  PE_ready;
  logic [DB-1:0] PE_data;
  logic          busy;

  int n_vec  = 0;
  int n_miss = 0;

  logic [XB-1:0] xval [N];
  logic [YB-1:0] yval [ROWS];

  always #5 clk = ~clk;

  gin_channel_receiver #(
    .NUMS_PE_ROW (ROWS),
    .NUMS_PE_COL (COLS),
    .XID_BITS    (XB),
    .YID_BITS    (YB),
    .DATA_SIZE   (DB)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .set_XID     (set_XID),
    .XID_scan_in (XID_scan_in),
    .set_YID     (set_YID),
    .YID_scan_in (YID_scan_in),
    .PE_en       (PE_en),
    .GLB_valid   (GLB_valid),
    .GLB_ready   (GLB_ready),
    .tag_X       (tag_X),
    .tag_Y       (tag_Y),
    .data_in     (data_in),
    .PE_valid    (PE_valid),
    .PE_ready    (PE_ready),
    .PE_data     (PE_data),
    .busy        (busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_x();
    set_XID = 1'b1;
    for (int i = 0; i < N; i++) begin
      XID_scan_in = xval[i];
      step();
    end
    set_XID = 1'b0;
  endtask

  task automatic load_y();
    set_YID = 1'b1;
    for (int j = 0; j < ROWS; j++) begin
      YID_scan_in = yval[j];
      step();
    end
    set_YID = 1'b0;
  endtask

  // One-cycle offer; returns in the cycle after the accept edge.
  task automatic offer(input logic [XB-1:0] tx, input logic [YB-1:0] ty, input logic [DB-1:0] d);
    GLB_valid = 1'b1;
    tag_X     = tx;
    tag_Y     = ty;
    data_in   = d;
    chk("offer_ready", {63'd0, GLB_ready}, 64'd1);
    step();
    GLB_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1);
  end

  logic [N-1:0] stg_valid [6];
  logic [N-1:0] stg_ready [6];

  initial begin
    rst_n = 1'b0; set_XID = 1'b0; XID_scan_in = '0; set_YID = 1'b0; YID_scan_in = '0;
    PE_en = ALL; GLB_valid = 1'b0; tag_X = '0; tag_Y = '0; data_in = '0; PE_ready = '0;
    step(); step();
    rst_n = 1'b1;

    // Reset state
    chk("rst_ready", {63'd0, GLB_ready}, 64'd1);
    chk("rst_valid", {16'd0, PE_valid}, 64'd0);
    chk("rst_busy",  {63'd0, busy}, 64'd0);
    chk("rst_data",  {32'd0, PE_data}, 64'd0);

    // Scan load: X = i mod 32, Y = row index
    for (int i = 0; i < N; i++) xval[i] = XB'(i % 32);
    for (int j = 0; j < ROWS; j++) yval[j] = YB'(j);
    load_x();
    load_y();
    offer(5'd3, 3'd0, 32'h1111_0003);
    chk("scan_x3y0_valid", {16'd0, PE_valid}, 64'h1 << 3);
    chk("scan_busy", {63'd0, busy}, 64'd1);
    chk("scan_ready_low", {63'd0, GLB_ready}, 64'd0);
    chk("scan_data", {32'd0, PE_data}, 64'h1111_0003);
    PE_ready = ALL;
    step();
    chk("scan_release", {63'd0, GLB_ready}, 64'd1);
    PE_ready = '0;
    offer(5'd3, 3'd4, 32'h1111_0035);
    chk("scan_x3y4_valid", {16'd0, PE_valid}, 64'h1 << 35);
    PE_ready = ALL;
    step();
    PE_ready = '0;

    // Multicast: every PE matches, all ready
    for (int i = 0; i < N; i++) xval[i] = '0;
    for (int j = 0; j < ROWS; j++) yval[j] = 3'd1;
    load_x();
    load_y();
    PE_ready = ALL;
    offer(5'd0, 3'd1, 32'hCAFE_0001);
    chk("mc_all_valid", {16'd0, PE_valid}, {16'd0, ALL});
    chk("mc_ready_low", {63'd0, GLB_ready}, 64'd0);
    step();
    chk("mc_valid_gone", {16'd0, PE_valid}, 64'd0);
    chk("mc_ready_back", {63'd0, GLB_ready}, 64'd1);
    PE_ready = '0;

    // Staggered ready on PEs 0, 8, 16
    for (int i = 0; i < N; i++) xval[i] = (i == 0 || i == 8 || i == 16) ? 5'd5 : 5'd9;
    load_x();
    stg_valid[0] = (1 << 0) | (1 << 8) | (1 << 16);  stg_ready[0] = 1 << 0;
    stg_valid[1] = (1 << 8) | (1 << 16);             stg_ready[1] = '0;
    stg_valid[2] = (1 << 8) | (1 << 16);             stg_ready[2] = 1 << 8;
    stg_valid[3] = 1 << 16;                          stg_ready[3] = '0;
    stg_valid[4] = 1 << 16;                          stg_ready[4] = 1 << 16;
    stg_valid[5] = '0;                               stg_ready[5] = '0;
    offer(5'd5, 3'd1, 32'hDEAD_BEEF);
    for (int c = 0; c < 6; c++) begin
      chk($sformatf("stg_valid_c%0d", c + 1), {16'd0, PE_valid}, {16'd0, stg_valid[c]});
      chk($sformatf("stg_ready_c%0d", c + 1), {63'd0, GLB_ready}, (c == 5) ? 64'd1 : 64'd0);
      if (c < 5) chk($sformatf("stg_data_c%0d", c + 1), {32'd0, PE_data}, 64'hDEAD_BEEF);
      PE_ready = stg_ready[c];
      step();
    end

    // No match: consumed in one cycle
    offer(5'd31, 3'd7, 32'h0BAD_0BAD);
    chk("nm_valid", {16'd0, PE_valid}, 64'd0);
    chk("nm_ready", {63'd0, GLB_ready}, 64'd1);
    chk("nm_busy",  {63'd0, busy}, 64'd0);

    // PE_en gating and scan during HOLD
    for (int i = 0; i < N; i++) xval[i] = (i == 2 || i == 10) ? 5'd7 : 5'd9;
    load_x();
    PE_en = ALL & ~(48'h1 << 10);
    offer(5'd7, 3'd1, 32'h0000_7777);
    chk("en_valid", {16'd0, PE_valid}, 64'h1 << 2);
    for (int i = 0; i < N; i++) xval[i] = 5'd7;
    PE_en = ALL;
    load_x();
    chk("hold_scan_valid", {16'd0, PE_valid}, 64'h1 << 2);
    chk("hold_scan_busy", {63'd0, busy}, 64'd1);
    PE_ready = 48'h1 << 2;
    step();
    PE_ready = '0;
    chk("en_release_valid", {16'd0, PE_valid}, 64'd0);
    chk("en_release_ready", {63'd0, GLB_ready}, 64'd1);
    offer(5'd7, 3'd1, 32'h0000_8888);
    chk("new_ids_valid", {16'd0, PE_valid}, {16'd0, ALL});

    // Reset mid-HOLD
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("mrst_valid", {16'd0, PE_valid}, 64'd0);
    chk("mrst_busy",  {63'd0, busy}, 64'd0);
    chk("mrst_ready", {63'd0, GLB_ready}, 64'd1);
    chk("mrst_data",  {32'd0, PE_data}, 64'd0);
    offer(5'd0, 3'd0, 32'h0000_0001);
    chk("mrst_ids_zero", {16'd0, PE_valid}, {16'd0, ALL});
    PE_ready = ALL;
    step();
    PE_ready = '0;
    offer(5'd7, 3'd1, 32'h0000_0002);
    chk("mrst_old_ids_gone", {16'd0, PE_valid}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/gin_channel_receiver.md
# gin_channel_receiver

Receiving end of one Global Input Network (GIN) channel inside the PE array. It holds the per-PE X IDs and per-row Y IDs loaded through the scan chains, and latches each tagged word the controller broadcasts with valid/ready. It multicasts that word to every enabled PE whose IDs match the tag, then releases the controller only after all matching PEs have taken it. One instance is built per channel: ifmap, filter and ipsum.

## Interface
Parameters:
- NUMS_PE_ROW, `NUMS_PE_ROW (6): PE rows.
- NUMS_PE_COL, `NUMS_PE_COL (8): PE columns.
- XID_BITS, `XID_BITS (5): X ID / X tag width.
- YID_BITS, `YID_BITS (3): Y ID / Y tag width.
- DATA_SIZE, `DATA_BITS (32): payload width.

Ports (N = NUMS_PE_ROW*NUMS_PE_COL):
- clk  in  1  single clock; all logic on posedge.
- rst_n  in  1  reset, synchronous, active-low.
- set_XID  in  1  shift enable for the X scan chain.
- XID_scan_in  in  XID_BITS  X chain serial input.
- set_YID  in  1  shift enable for the Y scan chain.
- YID_scan_in  in  YID_BITS  Y chain serial input.
- PE_en  in  N  per-PE enable; a disabled PE never matches.
- GLB_valid  in  1  controller word valid.
- GLB_ready  out  1  receiver can accept a word.
- tag_X  in  XID_BITS  X tag of the offered word.
- tag_Y  in  YID_BITS  Y tag of the offered word.
- data_in  in  DATA_SIZE  offered payload.
- PE_valid  out  N  per-PE valid.
- PE_ready  in  N  per-PE ready.
- PE_data  out  DATA_SIZE  payload broadcast to all PEs.
- busy  out  1  a word is held in the slot.

## Operation
- X scan chain: N entries. Each cycle set_XID=1, entry k takes entry k+1 and entry N-1 takes XID_scan_in. After exactly N shift cycles, PE i holds the value driven in shift cycle i.
- Y scan chain: NUMS_PE_ROW entries. Same shift scheme under set_YID. Row j holds the value driven in cycle j.
- PE i sits at row i / NUMS_PE_COL. It matches when PE_en[i] && XID[i]==tag_X && YID[row]==tag_Y.
- States:
  - EMPTY: GLB_ready=1. A handshake with a non-zero match mask latches data_in and the mask into pending, then moves to HOLD. A handshake with a zero mask consumes and drops the word; state stays EMPTY.
  - HOLD: GLB_ready=0. PE_valid = pending. Each cycle, bits with PE_valid[i]&&PE_ready[i] clear. When pending would become zero, the next state is EMPTY.
- The mask is frozen at accept. Scan shifts or PE_en changes during HOLD do not affect the in-flight word, but do apply to the next match.
- Scan shifting and data transfer may occur in the same cycle. Both take effect independently.

## Timing
- Reset values: XID and YID all 0; pending=0; state EMPTY; GLB_ready=1 while not in reset; PE_valid=0; PE_data=0; busy=0. Reset mid-HOLD discards the word.
- GLB_ready is a function of state only, with no combinational path from GLB_valid or PE_ready.
- Accept at edge T gives PE_valid and PE_data valid from cycle T+1.
- If all matched PEs are ready at T+1, the slot clears at edge T+1 and GLB_ready=1 in cycle T+2. Peak throughput is 1 word per 2 cycles.
- PE_data stays stable for the whole of HOLD.
- Partial acceptance: a PE that has accepted sees PE_valid drop the next cycle. It never receives the same word twice.
- A scan-loaded value is usable for matching in the cycle after its last shift edge.

## Structure
- Shared package gin_pkg holds:
  - the state enum {EMPTY, HOLD};
  - the N/ROW/COL derived constants;
  - a function pe_row(i) returning the row index of PE i.
- One sub-module, gin_id_scan_chain, parameterized by depth and width: a shift register with a parallel read-out. It is instantiated twice, once for X and once for Y.
- Match logic and the slot FSM live in the top module.

## Test plan
- Scan load: shift X values 0..47 mod 32 and Y values 0..5, then read back through matching. A word tagged X=3, Y=0 asserts only PE_valid[3].
- Multicast: set all XID=0 and all YID=1, tag (0,1), hold every PE_ready=1. All 48 PE_valid are high for exactly 1 cycle, and GLB_ready returns 2 cycles after accept.
- Staggered ready: the match mask has PEs 0, 8 and 16. Assert ready on PE 0 in cycle 1, PE 8 in cycle 3, PE 16 in cycle 5. Each PE_valid drops the cycle after its own ready. GLB_ready=0 until cycle 6, and PE_data holds 0xDEADBEEF throughout.
- No match: tag (31,7) is offered with no matching IDs. The word is consumed in 1 cycle, PE_valid stays 0 and GLB_ready stays 1.
- PE_en gating, and scan during HOLD: match 2 PEs with PE_en for one of them at 0, so only 1 PE_valid asserts. During HOLD, shift new XIDs; the pending mask is unchanged.
- Reset mid-HOLD: assert rst_n=0 for 1 cycle while pending is non-zero. Next cycle PE_valid=0, busy=0, GLB_ready=1 and all IDs read 0.
